// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the memory stage and a byte-lane data memory.
// Word-crossing accesses are split into two cycles when MISALIGN_SPLIT_EN is defined, otherwise they error.
module dmem_lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dwdata,
  output logic [3:0]        we,
  input  logic [DATA_W-1:0] drdata
);

`ifdef MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                st_q;
  logic                uns_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   lo_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic [7:0]          cur_mask;
  logic [2*DATA_W-1:0] wd64;
  logic [ADDR_W-1:0]   base;

  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'b0000_0001;
      2'b01:   m = 8'b0000_0011;
      default: m = 8'b0000_1111;
    endcase
    return m << off;
  endfunction

  // True when the access spills into the following word (mask8[7:4] != 0).
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
    logic c;
    case (size)
      2'b00:   c = 1'b0;
      2'b01:   c = (off == 2'b11);
      default: c = (off != 2'b00);
    endcase
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [2*DATA_W-1:0] d64,
                                                 input logic [1:0]          off,
                                                 input logic [1:0]          size,
                                                 input logic                uns);
    logic [2*DATA_W-1:0] sh;
    logic [DATA_W-1:0]   r;
    sh = d64 >> {off, 3'b000};
    case (size)
      2'b00:   r = {{(DATA_W-8){~uns & sh[7]}}, sh[7:0]};
      2'b01:   r = {{(DATA_W-16){~uns & sh[15]}}, sh[15:0]};
      default: r = sh[DATA_W-1:0];
    endcase
    return r;
  endfunction

  assign cur_mask  = lane_mask(addr_q[1:0], size_q);
  assign wd64      = {{DATA_W{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};
  assign base      = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Memory-side outputs decode from state, so an async reset clears we at once.
  always_comb begin
    daddr  = '0;
    dwdata = '0;
    we     = '0;
    case (state_q)
      ACC0: begin
        daddr  = base;
        dwdata = wd64[DATA_W-1:0];
        we     = st_q ? cur_mask[3:0] : 4'b0000;
      end
      ACC1: begin
        daddr  = base + ADDR_W'(4);
        dwdata = wd64[2*DATA_W-1:DATA_W];
        we     = st_q ? cur_mask[7:4] : 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      st_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            st_q    <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            if (req_size == 2'b11 || (!SplitEn && crosses(req_addr[1:0], req_size))) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ACC0;
            end
          end
        end
        ACC0: begin
          if (!st_q) lo_q <= drdata;
          if (SplitEn && crosses(addr_q[1:0], size_q)) begin
            state_q <= ACC1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= st_q ? '0
                                : load_ext({{DATA_W{1'b0}}, drdata}, addr_q[1:0], size_q, uns_q);
          end
        end
        ACC1: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= st_q ? '0 : load_ext({drdata, lo_q}, addr_q[1:0], size_q, uns_q);
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench for dmem_lsu_ctrl: byte-level reference memory model, directed cases, then random traffic.
module tb_dmem_lsu_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata, drdata;
  logic [3:0]    we;

  int checks = 0;
  int errors = 0;
  int unsigned pcyc = 0;
  int rdy_mode = 0;

  logic [7:0] dmem    [512] = '{default: 8'h00};
  logic [7:0] ref_mem [512] = '{default: 8'h00};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    int unsigned lat;
    int unsigned acc;
  } exp_t;
  exp_t sq[$];

  dmem_lsu_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  always_comb drdata = {dmem[{daddr[8:2], 2'b11}], dmem[{daddr[8:2], 2'b10}],
                        dmem[{daddr[8:2], 2'b01}], dmem[{daddr[8:2], 2'b00}]};

  always @(posedge clk)
    for (int l = 0; l < 4; l++)
      if (we[l]) dmem[{daddr[8:2], 2'(l)}] <= dwdata[8*l +: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte-by-byte memory semantics, independent of lane/state encoding.
  function automatic exp_t model(input logic wr, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int unsigned n, off;
    logic [31:0] v;
    logic [8:0]  idx;
    e.rdata = '0; e.err = 1'b0; e.wr = 1'b0; e.lat = 0; e.acc = 0;
    if (size == 2'b11) begin e.err = 1'b1; e.lat = 1; return e; end
    n   = 1 << size;
    off = addr[1:0];
    if (off + n > 4 && !SPLIT) begin e.err = 1'b1; e.lat = 1; return e; end
    e.lat = (off + n > 4) ? 3 : 2;
    if (wr) begin
      e.wr = 1'b1;
      for (int i = 0; i < int'(n); i++) begin
        idx = 9'(addr + 32'(i));
        ref_mem[idx] = wdata[8*i +: 8];
      end
    end else begin
      v = '0;
      for (int i = 0; i < int'(n); i++) begin
        idx = 9'(addr + 32'(i));
        v = v | (32'(ref_mem[idx]) << (8*i));
      end
      if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      e.rdata = v;
    end
    return e;
  endfunction

  // Called at a negedge; returns #1 after the accept edge.
  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit track);
    exp_t e;
    int unsigned w;
    req_valid = 1'b1; req_we = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept: req_ready stayed %b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e = model(wr, size, uns, addr, wdata);
      e.acc = pcyc;
      sq.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while ((sq.size() != 0 || rsp_valid) && w < 200) begin @(negedge clk); w++; end
    if (sq.size() != 0 || rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: %0d responses pending, required 0", sq.size());
    end
  endtask

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  bit          seen = 1'b0;
  logic [31:0] held_d;
  logic        held_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (sq.size() != 0 && !sq[0].wr) chk("we_zero_nonwrite", 32'(we), 32'd0);
      if (rsp_valid) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: rsp_valid=1 with no request outstanding");
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("rsp_latency", pcyc - sq[0].acc, sq[0].lat);
            held_d = rsp_rdata;
            held_e = rsp_err;
          end else begin
            chk("rsp_rdata_stable", rsp_rdata, held_d);
            chk("rsp_err_stable", 32'(rsp_err), 32'(held_e));
          end
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          if (rsp_ready) begin
            chk("rsp_rdata", rsp_rdata, sq[0].rdata);
            chk("rsp_err", 32'(rsp_err), 32'(sq[0].err));
            void'(sq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int unsigned w;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_daddr", daddr, 32'd0);
    chk("reset_dwdata", dwdata, 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // SW / LW aligned
    @(negedge clk); issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b1);
    chk("sw_acc0_daddr", daddr, 32'h10);
    chk("sw_acc0_we", 32'(we), 32'hF);
    chk("sw_acc0_dwdata", dwdata, 32'h11223344);
    drain();
    @(negedge clk); issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    drain();

    // Byte 0x80 at 0x13, signed and unsigned loads
    @(negedge clk); issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, 1'b1);
    drain();
    @(negedge clk); issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1);
    chk("lb_acc0_we", 32'(we), 32'd0);
    drain();
    @(negedge clk); issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1);
    chk("lbu_acc0_we", 32'(we), 32'd0);
    drain();

    // Word-crossing halfword store
    @(negedge clk); issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, 1'b1);
`ifdef MISALIGN_SPLIT_EN
    chk("sh_acc0_daddr", daddr, 32'h10);
    chk("sh_acc0_we", 32'(we), 32'b1000);
    chk("sh_acc0_lane3", 32'(dwdata[31:24]), 32'hEF);
    @(posedge clk); #1;
    chk("sh_acc1_daddr", daddr, 32'h14);
    chk("sh_acc1_we", 32'(we), 32'b0001);
    chk("sh_acc1_lane0", 32'(dwdata[7:0]), 32'hBE);
`else
    chk("sh_nosplit_we", 32'(we), 32'd0);
`endif
    drain();
    @(negedge clk); issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b1);
    drain();

    // Illegal size
    @(negedge clk); issue(1'b1, 2'b11, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1);
    chk("illegal_we", 32'(we), 32'd0);
    drain();

    // Response backpressure
    rdy_mode = 2;
    @(negedge clk); issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    w = 0;
    while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    end
    rdy_mode = 0;
    drain();

    // Address wrap at the top of the space
    @(negedge clk); issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hCAFEF00D, 1'b1);
    drain();
    @(negedge clk); issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b1);
    drain();

    // Reset during ACC0 of an aligned store: nothing may be written
    @(negedge clk); issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 1'b0);
    chk("rst0_we_before", 32'(we), 32'hF);
    rst_n = 1'b0; #1;
    chk("rst0_we", 32'(we), 32'd0);
    chk("rst0_req_ready", 32'(req_ready), 32'd1);
    chk("rst0_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;

`ifdef MISALIGN_SPLIT_EN
    // Reset during ACC1 of a split store: only the first-word lanes land
    @(negedge clk); issue(1'b1, 2'b10, 1'b0, 32'h0E, 32'hAABBCCDD, 1'b0);
    @(posedge clk); #1;
    chk("rst1_we_before", 32'(we), 32'b0011);
    rst_n = 1'b0; #1;
    chk("rst1_we", 32'(we), 32'd0);
    chk("rst1_req_ready", 32'(req_ready), 32'd1);
    chk("rst1_rsp_valid", 32'(rsp_valid), 32'd0);
    ref_mem[9'h0E] = 8'hDD;
    ref_mem[9'h0F] = 8'hCC;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst1_byte0E", 32'(dmem[9'h0E]), 32'hDD);
    chk("rst1_byte0F", 32'(dmem[9'h0F]), 32'hCC);
    chk("rst1_byte10", 32'(dmem[9'h10]), 32'(ref_mem[9'h10]));
    chk("rst1_byte11", 32'(dmem[9'h11]), 32'(ref_mem[9'h11]));
`endif

    // Random traffic with random response backpressure
    rdy_mode = 1;
    for (int k = 0; k < 400; k++) begin
      logic [1:0] sz;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 511));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      @(negedge clk);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end
    rdy_mode = 0;
    drain();

    for (int i = 0; i < 512; i++)
      chk($sformatf("mem_byte_%0h", i), 32'(dmem[i]), 32'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
